// File: rtl/core_streamer_pkg.sv
// Shared constants and FSM encoding for the feature streamer and its pooling consumer.
// Map geometry defaults must stay in step with the max-pooling core.
package core_streamer_pkg;
  localparam int DEF_DWIDTH = 32;
  localparam int DEF_WIDTH  = 112;
  localparam int DEF_HEIGHT = 112;
  localparam int DEF_AWIDTH = 14;
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/core_feature_streamer_if.sv
// RAM read port plus FIFO write port of the feature streamer.
// master = streamer side, slave = RAM/FIFO side.
interface core_feature_streamer_if
  import core_streamer_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) ();
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_rden;
  logic [DWIDTH-1:0] mem_rdata;
  logic [DWIDTH-1:0] ff_wdata;
  logic              ff_wrreq;
  logic              ff_full;

  modport master (
    output mem_addr, mem_rden, ff_wdata, ff_wrreq,
    input  mem_rdata, ff_full
  );

  modport slave (
    input  mem_addr, mem_rden, ff_wdata, ff_wrreq,
    output mem_rdata, ff_full
  );
endinterface

// File: rtl/core_feature_streamer_skid_fifo.sv
// Two-entry skid FIFO holding RAM read data until the output FIFO accepts it.
// Head is always entry 0; simultaneous push and pop are allowed.
module streamer_skid_fifo
  import core_streamer_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [DWIDTH-1:0]  din,
  input  logic               pop,
  output logic [DWIDTH-1:0]  head,
  output logic [SKID_CW-1:0] count
);
  localparam logic [SKID_CW-1:0] CNT_FULL = SKID_CW'(SKID_DEPTH);

  logic [DWIDTH-1:0] entry0;
  logic [DWIDTH-1:0] entry1;

  assign head = entry0;

  always_ff @(posedge clock) begin
    if (reset) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == '0) entry0 <= din;
          else             entry1 <= din;
          count <= count + SKID_CW'(1);
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - SKID_CW'(1);
        end
        2'b11: begin
          // count stays; with two entries the second moves up behind the new tail
          if (count == CNT_FULL) begin
            entry0 <= entry1;
            entry1 <= din;
          end else begin
            entry0 <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/core_feature_streamer.sv
// Streams one WIDTH x HEIGHT map from a 1-cycle-latency RAM into the pooling FIFO, 1 word/cycle.
// Optional backpressure counter enabled by FEATURE_STREAMER_STALL_CNT_EN.
module core_feature_streamer
  import core_streamer_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AWIDTH-1:0]       base_addr,
  output logic                    busy,
  output logic                    done,
  core_feature_streamer_if.master bus
`ifdef FEATURE_STREAMER_STALL_CNT_EN
  , output logic [31:0]           stall_cnt
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam int OW = SKID_CW + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [AWIDTH-1:0]  addr;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               inflight;
  logic               rden;
  logic               pop;
  logic               last_issue;
  logic               drained;
  logic [SKID_CW-1:0] skid_cnt;
  logic [DWIDTH-1:0]  skid_head;
  logic [OW-1:0]      occ_after;

  streamer_skid_fifo #(.DWIDTH(DWIDTH)) u_skid (
    .clock (clock),
    .reset (reset),
    .push  (inflight),
    .din   (bus.mem_rdata),
    .pop   (pop),
    .head  (skid_head),
    .count (skid_cnt)
  );

  assign pop           = (skid_cnt != '0) && !bus.ff_full;
  assign bus.ff_wrreq  = pop;
  assign bus.ff_wdata  = skid_head;
  assign bus.mem_rden  = rden;
  assign bus.mem_addr  = addr;

  // Occupancy the skid will have once this cycle's pop and the in-flight read settle.
  assign occ_after = OW'(skid_cnt) + OW'(inflight) - OW'(pop);
  assign drained   = !inflight && ((skid_cnt == '0) || ((skid_cnt == SKID_CW'(1)) && pop));

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    rden       = 1'b0;
    last_issue = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        rden       = (occ_after <= OW'(1));
        last_issue = rden && (col == COL_LAST) && (row == ROW_LAST);
        if (last_issue) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drained) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Raster order is contiguous in RAM, so the address is a plain incrementer.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr     <= '0;
      col      <= '0;
      row      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rden;
      if (state == ST_IDLE && start) begin
        addr <= base_addr;
        col  <= '0;
        row  <= '0;
      end else if (rden) begin
        addr <= addr + AWIDTH'(1);
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

`ifdef FEATURE_STREAMER_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      stall_cnt <= '0;
    end else if (busy && (skid_cnt != '0) && bus.ff_full && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_core_feature_streamer.sv
// Bench for core_feature_streamer: cycle tables on a 4x2 map plus randomized backpressure on 112x112.
module tb_core_feature_streamer;
  localparam int SW = 4;
  localparam int SH = 2;
  localparam int BW = 112;
  localparam int BH = 112;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BIG_N = BW * BH;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          start_s, start_b;
  logic [AW-1:0] base_s, base_b;
  logic          busy_s, done_s, busy_b, done_b;
`ifdef FEATURE_STREAMER_STALL_CNT_EN
  logic [31:0]   stall_s, stall_b;
`endif

  core_feature_streamer_if #(.DWIDTH(DW), .AWIDTH(AW)) bus_s ();
  core_feature_streamer_if #(.DWIDTH(DW), .AWIDTH(AW)) bus_b ();

  core_feature_streamer #(.DWIDTH(DW), .WIDTH(SW), .HEIGHT(SH), .AWIDTH(AW)) dut_s (
    .clock     (clock),
    .reset     (reset),
    .start     (start_s),
    .base_addr (base_s),
    .busy      (busy_s),
    .done      (done_s),
    .bus       (bus_s)
`ifdef FEATURE_STREAMER_STALL_CNT_EN
    , .stall_cnt (stall_s)
`endif
  );

  core_feature_streamer #(.DWIDTH(DW), .WIDTH(BW), .HEIGHT(BH), .AWIDTH(AW)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .start     (start_b),
    .base_addr (base_b),
    .busy      (busy_b),
    .done      (done_b),
    .bus       (bus_b)
`ifdef FEATURE_STREAMER_STALL_CNT_EN
    , .stall_cnt (stall_b)
`endif
  );

  // RAM contents are RAM[i] = i, one cycle read latency.
  always @(posedge clock) begin
    if (bus_s.mem_rden) bus_s.mem_rdata <= DW'(bus_s.mem_addr);
    if (bus_b.mem_rden) bus_b.mem_rdata <= DW'(bus_b.mem_addr);
  end

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          start;
    logic [AW-1:0] base;
    logic          full;
    logic          busy;
    logic          done;
    logic          wr;
    logic [DW-1:0] wdata;
    logic          rden;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic [AW-1:0] b, input logic f, input logic bz,
                     input logic dn, input logic wr, input logic [DW-1:0] wd,
                     input logic rd, input logic [AW-1:0] ad);
    vec_t v;
    v.start = st; v.base = b; v.full = f; v.busy = bz; v.done = dn;
    v.wr = wr; v.wdata = wd; v.rden = rd; v.addr = ad;
    tbl.push_back(v);
  endtask

  task automatic run_rows(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      @(posedge clock); #1;
      start_s       = tbl[i].start;
      base_s        = tbl[i].base;
      bus_s.ff_full = tbl[i].full;
      @(negedge clock);
      chk($sformatf("%s[%0d] busy", tag, i - first), 32'(busy_s), 32'(tbl[i].busy));
      chk($sformatf("%s[%0d] done", tag, i - first), 32'(done_s), 32'(tbl[i].done));
      chk($sformatf("%s[%0d] ff_wrreq", tag, i - first), 32'(bus_s.ff_wrreq), 32'(tbl[i].wr));
      if (tbl[i].wr) chk($sformatf("%s[%0d] ff_wdata", tag, i - first), bus_s.ff_wdata, tbl[i].wdata);
      chk($sformatf("%s[%0d] mem_rden", tag, i - first), 32'(bus_s.mem_rden), 32'(tbl[i].rden));
      if (tbl[i].rden) chk($sformatf("%s[%0d] mem_addr", tag, i - first), 32'(bus_s.mem_addr), 32'(tbl[i].addr));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, 32'(busy_s), 32'd0);
    chk({tag, " done"}, 32'(done_s), 32'd0);
    chk({tag, " ff_wrreq"}, 32'(bus_s.ff_wrreq), 32'd0);
    chk({tag, " ff_wdata"}, bus_s.ff_wdata, 32'd0);
    chk({tag, " mem_rden"}, 32'(bus_s.mem_rden), 32'd0);
    chk({tag, " mem_addr"}, 32'(bus_s.mem_addr), 32'd0);
`ifdef FEATURE_STREAMER_STALL_CNT_EN
    chk({tag, " stall_cnt"}, stall_s, 32'd0);
`endif
  endtask

  int s1_lo, s1_hi, s2_lo, s2_hi, s3_lo, s3_hi;

  initial begin
    reset = 1'b1; start_s = 1'b0; start_b = 1'b0; base_s = '0; base_b = '0;
    bus_s.ff_full = 1'b0; bus_b.ff_full = 1'b0;

    // Seq 1: base 0x10, no backpressure; writes cycles 3..10, done 11, busy 1..11.
    s1_lo = tbl.size();
    for (int c = 0; c <= 12; c++)
      add(c == 0, 14'h10, 1'b0, (c >= 1 && c <= 11), c == 11,
          (c >= 3 && c <= 10), 32'h10 + 32'(c - 3), (c >= 1 && c <= 8), 14'h10 + 14'(c - 1));
    s1_hi = tbl.size() - 1;

    // Seq 2: ff_full high cycles 4..9; writes at 3 then resume 10..16, done 17.
    s2_lo = tbl.size();
    for (int c = 0; c <= 18; c++) begin
      logic wr, rd;
      logic [DW-1:0] wd;
      logic [AW-1:0] ad;
      wr = (c == 3) || (c >= 10 && c <= 16);
      wd = (c == 3) ? 32'h10 : 32'h11 + 32'(c - 10);
      rd = (c >= 1 && c <= 3) || (c >= 10 && c <= 14);
      ad = (c <= 3) ? 14'h10 + 14'(c - 1) : 14'h13 + 14'(c - 10);
      add(c == 0, 14'h10, (c >= 4 && c <= 9), (c >= 1 && c <= 17), c == 17, wr, wd, rd, ad);
    end
    s2_hi = tbl.size() - 1;

    // Seq 3: second start during RUN and base_addr changed after accept: same result as seq 1.
    s3_lo = tbl.size();
    for (int c = 0; c <= 12; c++)
      add((c == 0) || (c == 4), (c == 0) ? 14'h10 : 14'h30, 1'b0, (c >= 1 && c <= 11), c == 11,
          (c >= 3 && c <= 10), 32'h10 + 32'(c - 3), (c >= 1 && c <= 8), 14'h10 + 14'(c - 1));
    s3_hi = tbl.size() - 1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset_state");
    @(posedge clock); #1;
    reset = 1'b0;

    run_rows(s1_lo, s1_hi, "plain");
    run_rows(s2_lo, s2_hi, "backpressure");
`ifdef FEATURE_STREAMER_STALL_CNT_EN
    chk("stall_cnt after backpressure", stall_s, 32'd6);
`endif
    run_rows(s3_lo, s3_hi, "restart_ignored");

    // Reset in cycle 5 of a run: outputs clear next cycle, nothing more written.
    run_rows(s1_lo, s1_lo + 4, "pre_reset");
    @(posedge clock); #1;
    reset = 1'b1; start_s = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("after_reset");
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk($sformatf("post_reset_quiet[%0d] ff_wrreq", i), 32'(bus_s.ff_wrreq), 32'd0);
    end
    run_rows(s1_lo, s1_hi, "fresh_after_reset");

    // Randomized backpressure on the full 112x112 map versus a queue of expected words.
    begin
      logic [DW-1:0] exp_q[$];
      logic [AW-1:0] b, rd_next;
      int cyc, wr_cnt, rd_cnt, viol, rd_bad;
      bit seen_done;
      b = AW'($urandom_range(0, (1 << AW) - BIG_N));
      for (int i = 0; i < BIG_N; i++) exp_q.push_back(DW'(b) + DW'(i));
      rd_next = b; cyc = 0; wr_cnt = 0; rd_cnt = 0; viol = 0; rd_bad = 0; seen_done = 1'b0;
      @(posedge clock); #1;
      start_b = 1'b1; base_b = b;
      @(posedge clock); #1;
      start_b = 1'b0; base_b = AW'($urandom);
      while (!seen_done && cyc < 60000 && nfail < 50) begin
        bus_b.ff_full = 1'($urandom_range(0, 1));
        @(negedge clock);
        if (bus_b.ff_wrreq) begin
          if (bus_b.ff_full) viol++;
          wr_cnt++;
          if (exp_q.size() == 0) chk("big extra write", 32'(wr_cnt), 32'(BIG_N));
          else chk($sformatf("big word %0d", wr_cnt - 1), bus_b.ff_wdata, exp_q.pop_front());
        end
        if (bus_b.mem_rden) begin
          if (bus_b.mem_addr !== rd_next) rd_bad++;
          rd_next = rd_next + AW'(1);
          rd_cnt++;
        end
        if (done_b) seen_done = 1'b1;
        @(posedge clock); #1;
        cyc++;
      end
      bus_b.ff_full = 1'b0;
      chk("big done within budget", 32'(seen_done), 32'd1);
      chk("big write count", 32'(wr_cnt), 32'(BIG_N));
      chk("big read count", 32'(rd_cnt), 32'(BIG_N));
      chk("big reads out of order", 32'(rd_bad), 32'd0);
      chk("big writes while full", 32'(viol), 32'd0);
      chk("big words left unwritten", 32'(exp_q.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
